// File: rtl/kill_event_queue_pkg.sv
// Shared types and default sizing for the enemy life cycle and kill queue.
package game_pkg;

  typedef enum logic [1:0] {
    ALIVE,
    DYING,
    DEAD
  } enemy_state_t;

  localparam int unsigned N_ENEMY_DEF        = 8;
  localparam int unsigned PEND_W_DEF         = 4;
  localparam int unsigned DYING_FRAMES_DEF   = 16;
  localparam int unsigned RESPAWN_FRAMES_DEF = 60;

  // Timer width large enough for the longer of the two countdown phases.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/kill_event_queue_life_fsm.sv
// Single-enemy life cycle: ALIVE -> DYING -> DEAD -> ALIVE, with its own frame timer.
module enemy_life_fsm
  import game_pkg::*;
#(
  parameter int unsigned DYING_FRAMES   = DYING_FRAMES_DEF,
  parameter int unsigned RESPAWN_FRAMES = RESPAWN_FRAMES_DEF
) (
  input  logic frame_clk,
  input  logic reset_n,
  input  logic flush,
  input  logic hit,
  output logic alive,
  output logic dying,
  output logic kill_evt
);

  localparam int unsigned TW = timer_width(DYING_FRAMES, RESPAWN_FRAMES);
  localparam logic [TW-1:0] DYING_LAST   = TW'(DYING_FRAMES - 1);
  localparam logic [TW-1:0] RESPAWN_LAST = TW'(RESPAWN_FRAMES - 1);

  enemy_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  always_ff @(posedge frame_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ALIVE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (flush) begin
      state_d = ALIVE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ALIVE: begin
          if (hit) begin
            state_d = DYING;
            timer_d = '0;
          end
        end
        DYING: begin
          if (timer_q == DYING_LAST) begin
            state_d = DEAD;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        DEAD: begin
          if (timer_q == RESPAWN_LAST) begin
            state_d = ALIVE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = ALIVE;
          timer_d = '0;
        end
      endcase
    end
  end

  assign alive    = (state_q == ALIVE);
  assign dying    = (state_q == DYING);
  assign kill_evt = (state_q == ALIVE) && hit && !flush;

endmodule

// File: rtl/kill_event_queue.sv
// Collects per-enemy deaths into a saturating pending counter and issues one kill pulse per frame.
module kill_event_queue
  import game_pkg::*;
#(
  parameter int unsigned N_ENEMY        = N_ENEMY_DEF,
  parameter int unsigned PEND_W         = PEND_W_DEF,
  parameter int unsigned DYING_FRAMES   = DYING_FRAMES_DEF,
  parameter int unsigned RESPAWN_FRAMES = RESPAWN_FRAMES_DEF
) (
  input  logic               frame_clk,
  input  logic               reset_n,
  input  logic               game_active,
  input  logic [N_ENEMY-1:0] hit,
  output logic [N_ENEMY-1:0] enemy_alive,
  output logic [N_ENEMY-1:0] enemy_dying,
  output logic               kill,
  output logic [PEND_W-1:0]  pending,
  output logic               overflow
);

  localparam int unsigned    SUM_W    = PEND_W + 4;
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << PEND_W) - 1);

  logic [N_ENEMY-1:0] kill_evt;
  logic               flush;

  logic [PEND_W-1:0]  pending_q, pending_d;
  logic               kill_q, kill_d;
  logic               overflow_q, overflow_d;

  logic [SUM_W-1:0]   new_kills;
  logic [SUM_W-1:0]   sum;
  logic               kill_next;

  assign flush = !game_active;

  for (genvar g = 0; g < N_ENEMY; g++) begin : g_enemy
    enemy_life_fsm #(
      .DYING_FRAMES  (DYING_FRAMES),
      .RESPAWN_FRAMES(RESPAWN_FRAMES)
    ) u_fsm (
      .frame_clk(frame_clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .hit      (hit[g]),
      .alive    (enemy_alive[g]),
      .dying    (enemy_dying[g]),
      .kill_evt (kill_evt[g])
    );
  end

  always_comb begin
    new_kills = '0;
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      new_kills = new_kills + SUM_W'(kill_evt[i]);
    end
  end

  always_comb begin
    kill_next  = (pending_q != '0);
    sum        = SUM_W'(pending_q) - SUM_W'(kill_next) + new_kills;
    pending_d  = pending_q;
    kill_d     = kill_q;
    overflow_d = overflow_q;
    if (flush) begin
      pending_d  = '0;
      kill_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      kill_d = kill_next;
      // Drop excess kills instead of wrapping; the loss is latched in overflow.
      if (sum > PEND_MAX) begin
        pending_d  = PEND_MAX[PEND_W-1:0];
        overflow_d = 1'b1;
      end else begin
        pending_d = sum[PEND_W-1:0];
      end
    end
  end

  always_ff @(posedge frame_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      kill_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      kill_q     <= kill_d;
      overflow_q <= overflow_d;
    end
  end

  assign kill     = kill_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule
